// File: rtl/prbs_pattern_gen.sv
// -----------------------------------------------------------------------------
// prbs_pattern_gen
//   Byte-stream stimulus source. On an accepted start it emits a captured
//   32-bit pattern n_repeats times (least-significant byte first), followed by
//   prbs_len PRBS-15 bytes, over a valid/ready handshake. A one-cycle done
//   pulse follows the final accepted byte.
//
// Parameters
//   SEED        PRBS-15 LFSR reload value (must be nonzero)
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   start       run request, only honoured in IDLE
//   abort       synchronous abort back to IDLE, beats start and transfers
//   pattern     32-bit pattern word, byte 0 = [7:0]
//   n_repeats   number of pattern words to emit
//   prbs_len    number of PRBS bytes after the pattern phase
//   data_out    registered output byte
//   data_valid  data_out holds a valid byte
//   data_ready  consumer accepts the byte
//   busy        high whenever the block is not IDLE
//   done        one-cycle pulse after the final byte is accepted
// -----------------------------------------------------------------------------
module prbs_pattern_gen #(
    parameter logic [14:0] SEED = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] pattern,
    input  logic [7:0]  n_repeats,
    input  logic [15:0] prbs_len,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PATTERN = 2'd1,
        PRBS    = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] pattern_q,    pattern_d;
    logic [7:0]  n_rep_q,      n_rep_d;
    logic [15:0] prbs_len_q,   prbs_len_d;
    logic [14:0] lfsr_q,       lfsr_d;
    logic [1:0]  byte_idx_q,   byte_idx_d;
    logic [7:0]  rep_cnt_q,    rep_cnt_d;
    logic [15:0] prbs_cnt_q,   prbs_cnt_d;
    logic [7:0]  data_out_q,   data_out_d;
    logic        data_valid_q, data_valid_d;

    // Eight serial LFSR steps in one cycle. Returns {next_state, byte} with
    // the first generated bit placed in the byte MSB.
    function automatic logic [22:0] prbs_step8(input logic [14:0] s_in);
        logic [14:0] s;
        logic [7:0]  b;
        logic        fb;
        s = s_in;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fb       = s[14] ^ s[13];
            b[7 - i] = fb;
            s        = {s[13:0], fb};
        end
        return {s, b};
    endfunction

    function automatic logic [7:0] pat_byte(input logic [31:0] p, input logic [1:0] idx);
        logic [7:0] r;
        case (idx)
            2'd0:    r = p[7:0];
            2'd1:    r = p[15:8];
            2'd2:    r = p[23:16];
            default: r = p[31:24];
        endcase
        return r;
    endfunction

    // lfsr_q always holds the state the *next* PRBS byte is generated from;
    // the byte on data_out was produced from the previous state.
    logic [14:0] lfsr_adv, seed_adv;
    logic [7:0]  prbs_lfsr_byte, prbs_seed_byte;
    logic        xfer;
    logic        last_pat_byte;
    logic        last_prbs_byte;

    always_comb begin
        {lfsr_adv, prbs_lfsr_byte} = prbs_step8(lfsr_q);
        {seed_adv, prbs_seed_byte} = prbs_step8(SEED);
    end

    assign xfer           = data_valid_q & data_ready;
    assign last_pat_byte  = (byte_idx_q == 2'd3) && (rep_cnt_q == 8'(n_rep_q - 8'd1));
    assign last_prbs_byte = (prbs_cnt_q == 16'(prbs_len_q - 16'd1));

    always_comb begin
        state_d      = state_q;
        pattern_d    = pattern_q;
        n_rep_d      = n_rep_q;
        prbs_len_d   = prbs_len_q;
        lfsr_d       = lfsr_q;
        byte_idx_d   = byte_idx_q;
        rep_cnt_d    = rep_cnt_q;
        prbs_cnt_d   = prbs_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;

        if (abort) begin
            // Abort wins over start and over any transfer this cycle.
            state_d      = IDLE;
            data_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pattern_d  = pattern;
                        n_rep_d    = n_repeats;
                        prbs_len_d = prbs_len;
                        byte_idx_d = 2'd0;
                        rep_cnt_d  = 8'd0;
                        prbs_cnt_d = 16'd0;
                        lfsr_d     = SEED;
                        if (n_repeats != 8'd0) begin
                            state_d      = PATTERN;
                            data_out_d   = pattern[7:0];
                            data_valid_d = 1'b1;
                        end else if (prbs_len != 16'd0) begin
                            state_d      = PRBS;
                            data_out_d   = prbs_seed_byte;
                            lfsr_d       = seed_adv;
                            data_valid_d = 1'b1;
                        end else begin
                            state_d      = DONE;
                            data_valid_d = 1'b0;
                        end
                    end
                end

                PATTERN: begin
                    if (xfer) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            rep_cnt_d = rep_cnt_q + 8'd1;
                        end
                        if (last_pat_byte) begin
                            if (prbs_len_q != 16'd0) begin
                                // Seamless hand-over: first PRBS byte is ready
                                // on the very next cycle.
                                state_d    = PRBS;
                                data_out_d = prbs_lfsr_byte;
                                lfsr_d     = lfsr_adv;
                            end else begin
                                state_d      = DONE;
                                data_valid_d = 1'b0;
                            end
                        end else begin
                            data_out_d = pat_byte(pattern_q, byte_idx_q + 2'd1);
                        end
                    end
                end

                PRBS: begin
                    if (xfer) begin
                        prbs_cnt_d = prbs_cnt_q + 16'd1;
                        if (last_prbs_byte) begin
                            state_d      = DONE;
                            data_valid_d = 1'b0;
                        end else begin
                            data_out_d = prbs_lfsr_byte;
                            lfsr_d     = lfsr_adv;
                        end
                    end
                end

                DONE: begin
                    state_d      = IDLE;
                    data_valid_d = 1'b0;
                end

                default: begin
                    state_d      = IDLE;
                    data_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pattern_q    <= 32'h0;
            n_rep_q      <= 8'h0;
            prbs_len_q   <= 16'h0;
            lfsr_q       <= SEED;
            byte_idx_q   <= 2'd0;
            rep_cnt_q    <= 8'd0;
            prbs_cnt_q   <= 16'd0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            n_rep_q      <= n_rep_d;
            prbs_len_q   <= prbs_len_d;
            lfsr_q       <= lfsr_d;
            byte_idx_q   <= byte_idx_d;
            rep_cnt_q    <= rep_cnt_d;
            prbs_cnt_q   <= prbs_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_prbs_pattern_gen
//   Directed + randomized bench for prbs_pattern_gen. Expected byte streams
//   come from a reference model: pattern bytes by shifting, PRBS bits from the
//   recurrence b[n] = b[n-15] ^ b[n-14] seeded by the 15 SEED bits.
// -----------------------------------------------------------------------------
module tb_prbs_pattern_gen;

    localparam logic [14:0] SEED_P = 15'h7FFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] pattern;
    logic [7:0]  n_repeats;
    logic [15:0] prbs_len;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    prbs_pattern_gen #(.SEED(SEED_P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .n_repeats  (n_repeats),
        .prbs_len   (prbs_len),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference stream: pattern words LSB byte first, then PRBS bytes MSB first.
    task automatic build_exp(input logic [31:0] pat, input logic [7:0] nr, input logic [15:0] pl);
        bit hist[$];
        logic [14:0] sd;
        logic [7:0]  b;
        exp_q.delete();
        for (int r = 0; r < int'(nr); r++)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'((pat >> (8 * k)) & 32'hFF));
        sd = SEED_P;
        for (int i = 14; i >= 0; i--) hist.push_back(sd[i]);   // oldest bit first
        for (int n = 0; n < int'(pl) * 8; n++) begin
            int idx = n + 15;
            hist.push_back(hist[idx - 15] ^ hist[idx - 14]);
        end
        for (int y = 0; y < int'(pl); y++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], 1'(hist[15 + 8 * y + j])};
            exp_q.push_back(b);
        end
    endtask

    // One complete run. stall: random data_ready; inj: second start mid-run.
    task automatic run(input logic [31:0] pat, input logic [7:0] nr, input logic [15:0] pl,
                       input bit stall, input bit inj, input string tag);
        bit       seen_done = 0;
        bit       stalled = 0;
        logic [7:0] prev_d = 8'h00;
        bit       rdy;
        int       limit;
        build_exp(pat, nr, pl);
        got_q.delete();
        limit = 8 * exp_q.size() + 50;
        @(negedge clk);
        pattern = pat; n_repeats = nr; prbs_len = pl; start = 1'b1; data_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1'b1);
        chk({tag, "_first_valid"}, data_valid, exp_q.size() != 0);
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (inj && cyc == 1) begin
                start = 1'b1; pattern = 32'h1234_5678; n_repeats = 8'd9; prbs_len = 16'd7;
            end else if (inj && cyc == 2) begin
                start = 1'b0;
            end
            if (done) begin
                seen_done = 1;
                chk({tag, "_done_novalid"}, data_valid, 1'b0);
                chk({tag, "_done_busy"}, busy, 1'b1);
                break;
            end
            if (stalled) begin
                chk({tag, "_stall_data"}, data_out, prev_d);
                chk({tag, "_stall_valid"}, data_valid, 1'b1);
            end
            if (!stall && got_q.size() < exp_q.size())
                chk({tag, "_nobubble"}, data_valid, 1'b1);
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            data_ready = rdy;
            if (data_valid && rdy) got_q.push_back(data_out);
            stalled = data_valid && !rdy;
            prev_d  = data_out;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, seen_done, 1'b1);
        @(negedge clk);
        chk({tag, "_busy_fall"}, busy, 1'b0);
        chk({tag, "_done_once"}, done, 1'b0);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        data_ready = 1'b0;
    endtask

    initial begin
        bit found;
        bit done_or;
        logic [31:0] rp;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = 32'h0;
        n_repeats = 8'd0; prbs_len = 16'd0; data_ready = 1'b0;
        #12;
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run, then reference bytes spelled out as constants.
        run(32'hDEADBEEF, 8'd2, 16'd0, 0, 0, "basic");
        chk("basic_b0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'hEF);
        chk("basic_b3", got_q.size() > 3 ? got_q[3] : 8'hxx, 8'hDE);

        // PRBS seed check.
        run(32'h0, 8'd0, 16'd3, 0, 0, "seed");
        chk("seed_b0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);
        chk("seed_b1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h02);

        // Backpressure.
        run(32'hDEADBEEF, 8'd2, 16'd0, 1, 0, "stall");

        // Degenerate: done at T+1 without any valid byte.
        run(32'hCAFEF00D, 8'd0, 16'd0, 0, 0, "degen");

        // Ignored start mid-run with config inputs changing.
        run(32'h0BAD_F00D, 8'd3, 16'd4, 0, 1, "ignstart");

        // Abort during the 3rd byte, simultaneous with a transfer.
        @(negedge clk);
        pattern = 32'hDEADBEEF; n_repeats = 8'd2; prbs_len = 16'd4; start = 1'b1; data_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_third", data_out, 8'hAD);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", data_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        done_or = 0;
        repeat (10) begin
            @(negedge clk);
            done_or |= done;
        end
        chk("abort_nodone", done_or, 1'b0);

        // Async reset mid-PRBS.
        @(negedge clk);
        pattern = 32'h1122_3344; n_repeats = 8'd1; prbs_len = 16'd20; start = 1'b1; data_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", data_out, 8'h00);
        chk("arst_valid", data_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        data_ready = 1'b0;
        run(32'h0, 8'd0, 16'd5, 0, 0, "replay");
        chk("replay_b0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);

        // Loopback: sliding 32-bit match over the captured stream.
        run(32'hA5C3_3C5A, 8'd4, 16'd40, 1, 0, "loop");
        found = 0;
        for (int i = 0; i + 3 < got_q.size(); i++)
            if ({got_q[i + 3], got_q[i + 2], got_q[i + 1], got_q[i]} == 32'hA5C3_3C5A) found = 1;
        chk("loop_found", found, 1'b1);

        // Randomized configurations.
        for (int t = 0; t < 4; t++) begin
            rp = $urandom;
            run(rp, 8'($urandom_range(0, 3)), 16'($urandom_range(0, 24)),
                1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
